// File: rtl/gamepad_event_queue_if.sv
// CPU read bus for the gamepad event queue. The CPU side is the master.
interface gamepad_event_queue_if;
    logic        addr_match;
    logic        read_stb;
    logic [1:0]  reg_sel;
    logic [31:0] data_out;
    logic        irq;

    modport master (output addr_match, read_stb, reg_sel, input data_out, irq);
    modport slave  (input addr_match, read_stb, reg_sel, output data_out, irq);
endinterface

// File: rtl/gamepad_event_queue.sv
// Turns gamepad button transitions into timestamped press/release events.
// Events are queued in a FIFO that the CPU drains through memory-mapped reads.
module gamepad_event_queue #(
    parameter int          DEPTH       = 16,
    parameter int          TICK_DIV    = 1000,
    parameter logic [31:0] BUTTON_MASK = 32'h3FFF_3FFF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           pad_state,
    gamepad_event_queue_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [31:0]   pad_q;
    logic [31:0]   reported;
    logic [31:0]   diff;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [8:0]    count_ext;
    logic          overflow;
    logic [15:0]   ts;
    logic [PW-1:0] presc;

    logic [4:0]    sel_idx;
    logic          rd_qual;
    logic          pop;
    logic          push;
    logic          push_ok;
    logic          full;
    logic          empty;
    logic [31:0]   new_event;
    logic [31:0]   rd_data;

    assign diff      = pad_q ^ reported;
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign count_ext = 9'(count);
    assign rd_qual   = bus.addr_match && bus.read_stb;
    assign pop       = rd_qual && (bus.reg_sel == 2'd0) && !empty;
    assign push_ok   = !full || pop;
    assign push      = (diff != 32'h0) && push_ok;
    assign bus.irq   = !empty;

    // Scan from the top down so the last hit wins: lowest changed bit first.
    always_comb begin
        sel_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (diff[i]) begin
                sel_idx = 5'(i);
            end
        end
    end

    assign new_event = {1'b1, pad_q[sel_idx], 1'b0, sel_idx, 8'h00, ts};

    always_comb begin
        rd_data = 32'h0;
        case (bus.reg_sel)
            2'd0: rd_data = empty ? 32'h0 : mem[rd_ptr];
            2'd1: rd_data = {overflow, empty, full, 20'h0, count_ext};
            2'd2: rd_data = reported;
            2'd3: rd_data = {16'h0, ts};
            default: rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_event;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pad_q        <= 32'h0;
            reported     <= 32'h0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            ts           <= 16'h0;
            presc        <= '0;
            bus.data_out <= 32'h0;
        end else begin
            pad_q <= pad_state & BUTTON_MASK;

            if (presc == PW'(TICK_DIV - 1)) begin
                presc <= '0;
                ts    <= ts + 16'd1;
            end else begin
                presc <= presc + PW'(1);
            end

            if (push) begin
                wr_ptr            <= wr_ptr + AW'(1);
                reported[sel_idx] <= pad_q[sel_idx];
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A stall in the same cycle as a STATUS read keeps the flag set.
            if ((diff != 32'h0) && !push_ok) begin
                overflow <= 1'b1;
            end else if (rd_qual && (bus.reg_sel == 2'd1)) begin
                overflow <= 1'b0;
            end

            bus.data_out <= rd_qual ? rd_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_gamepad_event_queue.sv
// Directed bench: dut_a (DEPTH=4, TICK_DIV=4) covers events, overflow and reset;
// dut_b (TICK_DIV=1) covers the 16-bit timestamp wrap.
module tb_gamepad_event_queue;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reset_n_b = 1'b0;
    logic [31:0] pad_a = 32'h0;
    logic [31:0] pad_b = 32'h0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_edges = 0;
    logic [31:0] rd;

    localparam logic [1:0] R_EVENT = 2'd0;
    localparam logic [1:0] R_STAT  = 2'd1;
    localparam logic [1:0] R_STATE = 2'd2;
    localparam logic [1:0] R_TIME  = 2'd3;

    gamepad_event_queue_if bus_a ();
    gamepad_event_queue_if bus_b ();

    gamepad_event_queue #(.DEPTH(4), .TICK_DIV(4), .BUTTON_MASK(32'h3FFF_3FFF)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .pad_state (pad_a),
        .bus       (bus_a)
    );

    gamepad_event_queue #(.DEPTH(16), .TICK_DIV(1), .BUTTON_MASK(32'h3FFF_3FFF)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n_b),
        .pad_state (pad_b),
        .bus       (bus_b)
    );

    always #5 clk = ~clk;

    // Edges seen by dut_a since its reset was released.
    always @(posedge clk) begin
        if (!reset_n) n_edges <= 0;
        else          n_edges <= n_edges + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_a(input logic [1:0] sel, output logic [31:0] d);
        bus_a.addr_match = 1'b1;
        bus_a.read_stb   = 1'b1;
        bus_a.reg_sel    = sel;
        tick(1);
        d = bus_a.data_out;
        bus_a.addr_match = 1'b0;
        bus_a.read_stb   = 1'b0;
    endtask

    task automatic read_b(input logic [1:0] sel, output logic [31:0] d);
        bus_b.addr_match = 1'b1;
        bus_b.read_stb   = 1'b1;
        bus_b.reg_sel    = sel;
        tick(1);
        d = bus_b.data_out;
        bus_b.addr_match = 1'b0;
        bus_b.read_stb   = 1'b0;
    endtask

    task automatic reset_a();
        pad_a   = 32'h0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    initial begin
        bus_a.addr_match = 1'b0;
        bus_a.read_stb   = 1'b0;
        bus_a.reg_sel    = 2'd0;
        bus_b.addr_match = 1'b0;
        bus_b.read_stb   = 1'b0;
        bus_b.reg_sel    = 2'd0;
        tick(1);
        reset_a();

        // Reset state
        check_val("rst_irq", {31'h0, bus_a.irq}, 32'h0);
        check_val("rst_dout", bus_a.data_out, 32'h0);

        // Single press: event written two edges after the pad change
        pad_a = 32'h0000_0001;
        tick(1);
        check_val("irq_lat1", {31'h0, bus_a.irq}, 32'h0);
        tick(1);
        check_val("irq_lat2", {31'h0, bus_a.irq}, 32'h1);
        read_a(R_EVENT, rd);
        check_val("ev_p0", rd & 32'hFFFF_0000, 32'hC000_0000);
        check_val("irq_after_pop", {31'h0, bus_a.irq}, 32'h0);
        read_a(R_EVENT, rd);
        check_val("ev_empty", rd, 32'h0);
        tick(1);
        check_val("dout_idle", bus_a.data_out, 32'h0);

        // Three simultaneous presses come out lowest index first
        reset_a();
        pad_a = 32'h0001_0021;
        tick(4);
        read_a(R_STAT, rd);
        check_val("stat_3", rd, 32'h0000_0003);
        read_a(R_EVENT, rd);
        check_val("ev_b0", rd & 32'hFFFF_0000, 32'hC000_0000);
        read_a(R_EVENT, rd);
        check_val("ev_b5", rd & 32'hFFFF_0000, 32'hC500_0000);
        read_a(R_EVENT, rd);
        check_val("ev_b16", rd & 32'hFFFF_0000, 32'hD000_0000);
        read_a(R_STATE, rd);
        check_val("state", rd, 32'h0001_0021);

        // One-cycle tap gives press then release
        reset_a();
        pad_a = 32'h0000_0008;
        tick(1);
        pad_a = 32'h0;
        tick(4);
        read_a(R_STAT, rd);
        check_val("tap_cnt", rd, 32'h0000_0002);
        read_a(R_EVENT, rd);
        check_val("tap_press", rd & 32'hFFFF_0000, 32'hC300_0000);
        read_a(R_EVENT, rd);
        check_val("tap_rel", rd & 32'hFFFF_0000, 32'h8300_0000);
        pad_a = 32'h0000_0008;
        tick(1);
        pad_a = 32'h0000_0018;
        tick(4);
        read_a(R_EVENT, rd);
        check_val("seq_b3", rd & 32'hFFFF_0000, 32'hC300_0000);
        read_a(R_EVENT, rd);
        check_val("seq_b4", rd & 32'hFFFF_0000, 32'hC400_0000);

        // Overflow with DEPTH=4: six presses, nothing lost
        reset_a();
        pad_a = 32'h0000_003F;
        tick(8);
        read_a(R_STAT, rd);
        check_val("ovf_stat", rd, 32'hA000_0004);
        for (int i = 0; i < 6; i++) begin
            read_a(R_EVENT, rd);
            check_val("ovf_drain", rd & 32'hFFFF_0000, 32'hC000_0000 | (32'(i) << 24));
        end
        read_a(R_STAT, rd);
        check_val("ovf_sticky", rd, 32'hC000_0000);
        read_a(R_STAT, rd);
        check_val("ovf_clear", rd, 32'h4000_0000);

        // Timestamp: push at edge 13 after reset carries tick 3
        reset_a();
        tick(11);
        pad_a = 32'h0000_0080;
        tick(2);
        read_a(R_EVENT, rd);
        check_val("ev_ts", rd, 32'hC700_0003);
        tick(6);
        read_a(R_TIME, rd);
        check_val("time_rd", rd, 32'((n_edges - 1) / 4));

        // Mid-operation reset discards queued events
        reset_a();
        pad_a = 32'h0000_0007;
        tick(5);
        read_a(R_STAT, rd);
        check_val("pre_rst", rd, 32'h0000_0003);
        pad_a   = 32'h0;
        reset_n = 1'b0;
        tick(1);
        check_val("in_rst_irq", {31'h0, bus_a.irq}, 32'h0);
        check_val("in_rst_dout", bus_a.data_out, 32'h0);
        tick(1);
        reset_n = 1'b1;
        read_a(R_STAT, rd);
        check_val("post_rst", rd, 32'h4000_0000);

        // Strobe without address match returns 0
        bus_a.read_stb = 1'b1;
        bus_a.reg_sel  = R_STAT;
        tick(1);
        check_val("no_match", bus_a.data_out, 32'h0);
        bus_a.read_stb = 1'b0;

        // Reserved bits never generate events
        pad_a = 32'h4000_4000;
        tick(3);
        pad_a = 32'h8000_8000;
        tick(3);
        pad_a = 32'h0;
        tick(3);
        read_a(R_STAT, rd);
        check_val("rsvd_bits", rd, 32'h4000_0000);

        // Button held through reset: press lands two edges after release
        pad_a = 32'h0000_0002;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check_val("held_lat1", {31'h0, bus_a.irq}, 32'h0);
        tick(1);
        check_val("held_lat2", {31'h0, bus_a.irq}, 32'h1);
        read_a(R_EVENT, rd);
        check_val("held_ev", rd, 32'hC100_0000);

        // 16-bit timestamp wrap on dut_b (one tick per clock)
        reset_n_b = 1'b1;
        read_b(R_STAT, rd);
        check_val("b_stat", rd, 32'h4000_0000);
        tick(65534);
        read_b(R_TIME, rd);
        check_val("b_ffff", rd, 32'h0000_FFFF);
        read_b(R_TIME, rd);
        check_val("b_wrap", rd, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gamepad_event_queue.md
# gamepad_event_queue

Sits directly downstream of the gamepad input register block and consumes its packed 32-bit two-player button state (`{p2_state, p1_state}`). It converts every button transition into a timestamped press/release event, buffers the events in a FIFO, and exposes the queue to the CPU as memory-mapped registers plus a level interrupt. Software then sees every tap, including ones shorter than its polling interval.

## Interface
- `DEPTH`, 16: FIFO depth in events; power of two, 2..256.
- `TICK_DIV`, 1000: `clk` cycles per timestamp tick; ≥1.
- `BUTTON_MASK`, 32'h3FFF_3FFF: bits of `pad_state` that generate events. Reserved bits 14/15/30/31 are masked.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `pad_state` in 32: packed button state from the gamepad input block. Bit i set means pressed; p1 is [15:0], p2 is [31:16].
- `addr_match` in 1: CPU is addressing this block.
- `read_stb` in 1: CPU read request.
- `reg_sel` in 2: register select (CPU address bits [3:2]).
- `data_out` out 32: registered read data.
- `irq` out 1: high while the FIFO is non-empty.

## Operation
- `pad_q` is a register of `pad_state & BUTTON_MASK`, updated every cycle.
- `reported` is a 32-bit register holding the last state that was queued.
- Each cycle:
  - diff = `pad_q ^ reported`.
  - If diff ≠ 0 and a push is allowed, take i = lowest set bit of diff.
  - Push event {1'b1, `pad_q[i]`, 1'b0, i[4:0], 8'h00, ts[15:0]}. Layout: [31] valid, [30] press=1/release=0, [28:24] bit index, [15:0] timestamp.
  - Set `reported[i] <= pad_q[i]`.
- Glitches: a press and release both completed before the bit is scanned produce no event.
- Push allowed when FIFO not full, or when a pop happens in the same cycle (count unchanged).
- Overflow: if diff ≠ 0 and push is not allowed:
  - Scanning stalls; `reported` is unchanged and no event is lost or reordered.
  - Sticky `overflow` is set.
- Timestamp:
  - Prescaler counts 0..TICK_DIV-1.
  - `ts` increments by 1 when the prescaler wraps.
  - `ts` is 16 bits and wraps FFFF→0000.
- Registers are read only when `addr_match && read_stb`, by `reg_sel`:
  - 0 EVENT: returns the FIFO head and pops it. If the FIFO is empty, returns 0 (valid=0) and nothing is popped.
  - 1 STATUS: [31] overflow, [30] empty, [29] full, [8:0] count. Reading clears `overflow`; if an overflow condition occurs in the same cycle, `overflow` stays set.
  - 2 STATE: returns `reported`.
  - 3 TIME: returns {16'h0, ts}.
- Writes are not supported and are ignored.
- `data_out` is 0 in any cycle without a qualified read.

## Timing
- Reset (`reset_n`=0 at a rising edge) clears:
  - FIFO pointers, count, `overflow`, `reported`, `pad_q`, `ts`, prescaler, `data_out` (all to 0).
  - `irq` goes to 0.
- Mid-operation reset discards queued events.
- Buttons held through reset produce press events starting 2 cycles after release of reset.
- Event latency: `pad_state` change before edge E → `pad_q` updates at E → event written at E+1 → count and `irq` updated after E+1.
- Throughput: at most one event per cycle. N simultaneous changes need N cycles, lowest index first.
- Read latency: qualified read sampled at edge R → `data_out` valid after R. The pop takes effect at R, and a back-to-back read at R+1 returns the next event.
- Pop and push in the same cycle at count=DEPTH: push accepted, count stays DEPTH, full stays 1.
- Pop and push in the same cycle at count=0: the pop returns 0, then the event is written (count=1).
- Reading STATUS in the same cycle as a push reports the pre-push count.
- `irq` = (count ≠ 0), taken from the registered count with no extra delay.

## Test plan
- Reset, then set `pad_state`=32'h0000_0001 (P1 bit 0) → after 2 cycles, count=1 and `irq`=1; EVENT read returns 32'hC000_xxxx with index 0. Next EVENT read returns 0 and `irq`=0.
- Set `pad_state` bits 0, 5 and 16 in one cycle → three events in index order 0, 5, 16, all press. STATE reads 32'h0001_0021.
- Raise bit 3 for one cycle only, then drop it → one press event followed by one release event (bit 30=0, index 3). Raising bit 3 and then bits 3 and 4 together yields events in index order.
- With DEPTH=4, toggle 6 distinct buttons without reading → count=4, full=1, overflow=1. Drain 4 events, then the remaining 2 arrive in index order. The next STATUS read shows overflow=1 and the following STATUS read shows 0.
- With TICK_DIV=4, hold for 4×0x10000 cycles → TIME wraps to 0. An event pushed at tick 0x0003 carries [15:0]=0x0003.
- Assert `reset_n`=0 with 3 events queued → after reset, STATUS reads 32'h4000_0000 and `data_out`=0. Bit 14 toggling in `pad_state` never produces an event.
